// File: rtl/spi_rx_sampler.sv
// SPI receive stage: oversamples cs/sclk/mosi in the clk domain, rebuilds LSB-first frames
// and presents each completed word through a valid/ready output register.
module spi_rx_sampler #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DATA_W);

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_d_q, sclk_d_q;
  logic                   rise, fall, cs_rise;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic                   armed_q, armed_d;
  logic                   long_q, long_d;
  logic                   deliver;

  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   handshake;

  // Synchronisers reset to the idle bus levels so reset release creates no edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_d_q      <= 1'b1;
      sclk_d_q    <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_d_q      <= cs_s;
      sclk_d_q    <= sclk_s;
    end
  end

  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d_q;
  assign fall    = ~sclk_s & sclk_d_q;
  assign cs_rise = cs_s & ~cs_d_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    long_d      = long_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        armed_d   = 1'b0;
        long_d    = 1'b0;
        if (!cs_d_q) state_d = StRecv;
      end
      StRecv: begin
        // A fall only counts if its rise happened with cs already low.
        if (fall && armed_q) begin
          armed_d = 1'b0;
          if (bit_cnt_q < CntFull) begin
            shift_d   = {mosi_s, shift_q[DATA_W-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            long_d = 1'b1;
          end
        end else if (rise && !cs_d_q) begin
          armed_d = 1'b1;
        end
        if (cs_rise) state_d = StDone;
      end
      StDone: begin
        if (bit_cnt_q == CntFull && !long_q) begin
          deliver = 1'b1;
        end else if (bit_cnt_q != '0) begin
          frame_err_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign handshake = dout_valid_q & dout_ready;

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
    if (deliver) begin
      if (!dout_valid_q || handshake) begin
        dout_d       = shift_q;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      armed_q      <= 1'b0;
      long_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      long_q       <= long_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q == StRecv);

endmodule

// File: tb/tb_spi_rx_sampler.sv
// Directed bench for spi_rx_sampler: drives SPI frames at 1/8 clk rate and checks
// delivered words, error and overrun pulses against hand-computed values.
module tb_spi_rx_sampler;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst, cs, sclk, mosi, dout_ready;
  logic [DW-1:0] dout;
  logic          dout_valid, frame_err, overrun, busy;

  int n_total = 0;
  int n_bad   = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  int word_cnt = 0;
  logic [DW-1:0] words[$];

  always #5 clk = ~clk;

  spi_rx_sampler #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .sclk       (sclk),
    .mosi       (mosi),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Counts pulse cycles and records accepted words, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (overrun) ovr_cnt++;
    if (dout_valid && dout_ready) begin
      words.push_back(dout);
      word_cnt++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drop cs together with a (non-arming) sclk rise, then return sclk low.
  task automatic cs_open();
    cs = 1'b0; sclk = 1'b1; mosi = 1'b1;
    step(4);
    sclk = 1'b0;
    step(4);
  endtask

  task automatic drive_bits(input logic [15:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = data[i % 16];
      sclk = 1'b1;
      step(4);
      sclk = 1'b0;
      step(4);
    end
  endtask

  task automatic send_frame(input string tag, input logic [15:0] data, input int nbits);
    cs_open();
    drive_bits(data, nbits);
    check({tag, "_busy"}, int'(busy), 1);
    cs = 1'b1;
    mosi = 1'b0;
    step(12);
  endtask

  int e0, o0, w0;

  initial begin
    rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; dout_ready = 1'b0;
    step(3);
    check("rst_dout", int'(dout), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    step(3);

    // Single frame, consumer always ready.
    dout_ready = 1'b1;
    e0 = err_cnt; o0 = ovr_cnt; w0 = word_cnt;
    send_frame("a5c", 16'hA5C, 12);
    check("a5c_words", word_cnt - w0, 1);
    check("a5c_data", int'(words[w0]), 'hA5C);
    check("a5c_err", err_cnt - e0, 0);
    check("a5c_ovr", ovr_cnt - o0, 0);
    check("a5c_valid_clr", int'(dout_valid), 0);

    // Two frames with consumer stalled: second is dropped.
    dout_ready = 1'b0;
    e0 = err_cnt; o0 = ovr_cnt; w0 = word_cnt;
    send_frame("stall1", 16'h001, 12);
    send_frame("stall2", 16'h800, 12);
    check("stall_ovr", ovr_cnt - o0, 1);
    check("stall_err", err_cnt - e0, 0);
    check("stall_valid", int'(dout_valid), 1);
    check("stall_dout", int'(dout), 'h001);
    dout_ready = 1'b1;
    step(1);
    dout_ready = 1'b0;
    step(2);
    check("stall_acc_valid", int'(dout_valid), 0);
    check("stall_acc_words", word_cnt - w0, 1);
    check("stall_acc_data", int'(words[w0]), 'h001);

    // Same two frames with consumer always ready.
    dout_ready = 1'b1;
    e0 = err_cnt; o0 = ovr_cnt; w0 = word_cnt;
    send_frame("rdy1", 16'h001, 12);
    send_frame("rdy2", 16'h800, 12);
    check("rdy_words", word_cnt - w0, 2);
    check("rdy_data0", int'(words[w0]), 'h001);
    check("rdy_data1", int'(words[w0 + 1]), 'h800);
    check("rdy_ovr", ovr_cnt - o0, 0);

    // Short frame, then a good one.
    e0 = err_cnt; o0 = ovr_cnt; w0 = word_cnt;
    send_frame("short", 16'h3C3, 7);
    check("short_err", err_cnt - e0, 1);
    check("short_words", word_cnt - w0, 0);
    check("short_valid", int'(dout_valid), 0);
    e0 = err_cnt; w0 = word_cnt;
    send_frame("after_short", 16'h3C3, 12);
    check("after_short_words", word_cnt - w0, 1);
    check("after_short_data", int'(words[w0]), 'h3C3);
    check("after_short_err", err_cnt - e0, 0);

    // Long frame: 13 falls.
    e0 = err_cnt; o0 = ovr_cnt; w0 = word_cnt;
    send_frame("long", 16'h1ABC, 13);
    check("long_err", err_cnt - e0, 1);
    check("long_words", word_cnt - w0, 0);
    check("long_ovr", ovr_cnt - o0, 0);

    // Asynchronous reset five bits into a frame.
    cs_open();
    drive_bits(16'h015, 5);
    check("mid_busy", int'(busy), 1);
    check("mid_dout_pre", int'(dout), 'h3C3);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_dout", int'(dout), 0);
    check("mid_rst_valid", int'(dout_valid), 0);
    check("mid_rst_ferr", int'(frame_err), 0);
    check("mid_rst_ovr", int'(overrun), 0);
    check("mid_rst_busy", int'(busy), 0);
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    step(3);
    rst = 1'b1;
    step(3);
    e0 = err_cnt; o0 = ovr_cnt; w0 = word_cnt;
    send_frame("post_rst", 16'hFFF, 12);
    check("post_rst_words", word_cnt - w0, 1);
    check("post_rst_data", int'(words[w0]), 'hFFF);
    check("post_rst_err", err_cnt - e0, 0);
    check("post_rst_ovr", ovr_cnt - o0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
